// File: rtl/divider_iterative_if.sv
// divider_iterative_if
//   Handshake/operand bundle for the iterative divider.
//   master: requester side (drives valid_in/a/b, observes results)
//   slave : divider side   (samples operands, drives results)
//   Signals:
//     valid_in    start strobe; a/b sampled on the same edge
//     a           2*WIDTH-bit dividend
//     b           WIDTH-bit divisor
//     busy        division in progress
//     valid_out   one-cycle result pulse
//     q, rem      quotient and remainder
//     div_by_zero b was zero for the completed operation
//     overflow    quotient would not fit in WIDTH bits
interface divider_iterative_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 valid_in;
    logic [2*WIDTH-1:0]   a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 valid_out;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     rem;
    logic                 div_by_zero;
    logic                 overflow;

    modport master (
        output valid_in, a, b,
        input  busy, valid_out, q, rem, div_by_zero, overflow
    );

    modport slave (
        input  valid_in, a, b,
        output busy, valid_out, q, rem, div_by_zero, overflow
    );
endinterface

// File: rtl/divider_iterative.sv
// divider_iterative
//   Unsigned restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
//   one quotient bit per clock. Divide-by-zero and quotient overflow are
//   detected at start and reported one edge later without entering RUN.
//   A new start while busy aborts the running operation.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    divider_iterative_if.slave (operands in, results out)
module divider_iterative #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    divider_iterative_if.slave     bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   p_q, p_d;       // partial remainder
    logic [WIDTH-1:0]   d_q, d_d;       // divisor
    logic [WIDTH-1:0]   l_q, l_d;       // dividend low word, shifted out MSB first
    logic [WIDTH-1:0]   qs_q, qs_d;     // quotient shift register
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;
    logic               vout_q, vout_d;

    logic [WIDTH:0]     t;
    logic               ge;
    logic [WIDTH-1:0]   p_sub;
    logic [WIDTH-1:0]   p_step;
    logic [WIDTH-1:0]   qs_step;
    logic [WIDTH-1:0]   a_hi;
    logic [WIDTH-1:0]   a_lo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            d_q     <= '0;
            l_q     <= '0;
            qs_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            vout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            d_q     <= d_d;
            l_q     <= l_d;
            qs_q    <= qs_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            vout_q  <= vout_d;
        end
    end

    always_comb begin
        a_hi    = bus.a[2*WIDTH-1:WIDTH];
        a_lo    = bus.a[WIDTH-1:0];

        // 33-bit trial: since P < D, the difference always fits in WIDTH
        // bits, so the low WIDTH bits of T - D are the exact result.
        t       = {p_q, l_q[WIDTH-1]};
        ge      = (t >= {1'b0, d_q});
        p_sub   = t[WIDTH-1:0] - d_q;
        p_step  = ge ? p_sub : t[WIDTH-1:0];
        qs_step = (qs_q << 1) | WIDTH'(ge);

        state_d = state_q;
        p_d     = p_q;
        d_d     = d_q;
        l_d     = l_q;
        qs_d    = qs_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        vout_d  = 1'b0;

        if (bus.valid_in) begin
            if (bus.b == '0) begin
                state_d = IDLE;
                q_d     = '1;
                rem_d   = a_lo;
                dbz_d   = 1'b1;
                ovf_d   = 1'b0;
                vout_d  = 1'b1;
            end else if (a_hi >= bus.b) begin
                state_d = IDLE;
                q_d     = '1;
                rem_d   = '0;
                dbz_d   = 1'b0;
                ovf_d   = 1'b1;
                vout_d  = 1'b1;
            end else begin
                state_d = RUN;
                p_d     = a_hi;
                l_d     = a_lo;
                d_d     = bus.b;
                qs_d    = '0;
                cnt_d   = '0;
            end
        end else if (state_q == RUN) begin
            p_d   = p_step;
            qs_d  = qs_step;
            l_d   = l_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d = IDLE;
                q_d     = qs_step;
                rem_d   = p_step;
                dbz_d   = 1'b0;
                ovf_d   = 1'b0;
                vout_d  = 1'b1;
            end
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.valid_out   = vout_q;
    assign bus.q           = q_q;
    assign bus.rem         = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_divider_iterative.sv
// tb_divider_iterative
//   Self-checking bench for divider_iterative: directed cases plus random
//   operands compared with a plain-arithmetic reference model.
module tb_divider_iterative;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    divider_iterative_if #(.WIDTH(32)) bus ();

    divider_iterative #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exceptions decided from operand values, otherwise ordinary
    // 64-bit integer division.
    task automatic model(input logic [63:0] a, input logic [31:0] b,
                         output logic [31:0] eq, output logic [31:0] er,
                         output logic edbz, output logic eovf, output int elat);
        logic [63:0] b64;
        b64 = {32'd0, b};
        if (b == 32'd0) begin
            eq = 32'hFFFF_FFFF; er = a[31:0]; edbz = 1'b1; eovf = 1'b0; elat = 0;
        end else if ((a >> 32) >= b64) begin
            eq = 32'hFFFF_FFFF; er = 32'd0; edbz = 1'b0; eovf = 1'b1; elat = 0;
        end else begin
            eq = 32'(a / b64); er = 32'(a % b64); edbz = 1'b0; eovf = 1'b0; elat = 32;
        end
    endtask

    task automatic do_op(input logic [63:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        logic        edbz, eovf;
        int          elat, lat;
        model(a, b, eq, er, edbz, eovf, elat);
        bus.valid_in = 1'b1;
        bus.a        = a;
        bus.b        = b;
        tick();
        bus.valid_in = 1'b0;
        check("busy_start", bus.busy, (elat != 0));
        lat = 0;
        while (bus.valid_out !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", lat, elat);
        check("q", bus.q, eq);
        check("rem", bus.rem, er);
        check("div_by_zero", bus.div_by_zero, edbz);
        check("overflow", bus.overflow, eovf);
        check("busy_done", bus.busy, 1'b0);
        if (elat != 0) begin
            check("identity", 64'(bus.q) * 64'(b) + 64'(bus.rem), a);
            check("rem_lt_b", (bus.rem < b), 1'b1);
        end
        tick();
        check("pulse_one", bus.valid_out, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_vout"}, bus.valid_out, 1'b0);
        check({tag, "_q"}, bus.q, 32'd0);
        check({tag, "_rem"}, bus.rem, 32'd0);
        check({tag, "_dbz"}, bus.div_by_zero, 1'b0);
        check({tag, "_ovf"}, bus.overflow, 1'b0);
    endtask

    initial begin
        logic [31:0] rb, rhi, rlo, hold_q, hold_r;
        int          seen;
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        bus.valid_in = 1'b0;
        bus.a        = '0;
        bus.b        = '0;

        // Reset dominates a start strobe.
        bus.valid_in = 1'b1;
        bus.a        = 64'd100;
        bus.b        = 32'd7;
        tick();
        tick();
        bus.valid_in = 1'b0;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Directed cases.
        do_op(64'd100, 32'd7);
        do_op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
        do_op(64'h0000_0001_0000_0000, 32'd2);
        do_op(64'd12345, 32'd0);
        do_op(64'h0000_0005_0000_0000, 32'd5);
        do_op(64'h0000_0004_FFFF_FFFF, 32'd5);
        do_op(64'd0, 32'd1);
        do_op(64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF);

        // Abort/restart: first operation must never report.
        hold_q = bus.q;
        hold_r = bus.rem;
        bus.valid_in = 1'b1;
        bus.a        = 64'd100;
        bus.b        = 32'd7;
        tick();
        bus.valid_in = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.valid_out) seen++;
            tick();
        end
        check("abort_no_vout", seen, 0);
        check("abort_hold_q", bus.q, hold_q);
        check("abort_hold_rem", bus.rem, hold_r);
        do_op(64'd50, 32'd6);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.valid_out) seen++;
            tick();
        end
        check("abort_single_vout", seen, 0);

        // Restart on the completing edge.
        bus.valid_in = 1'b1;
        bus.a        = 64'd77;
        bus.b        = 32'd3;
        tick();
        bus.valid_in = 1'b0;
        for (int i = 0; i < 31; i++) tick();
        do_op(64'd1000, 32'd9);

        // Reset mid-operation.
        bus.valid_in = 1'b1;
        bus.a        = 64'd1000;
        bus.b        = 32'd3;
        tick();
        bus.valid_in = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_zero_outputs("midreset");
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.valid_out) seen++;
            tick();
        end
        check("midreset_no_vout", seen, 0);
        do_op(64'd9, 32'd4);

        // Random regression, mostly in-range with occasional exceptions.
        for (int n = 0; n < 1000; n++) begin
            rb = $urandom;
            if ($urandom_range(3) == 0) rb = rb >> $urandom_range(31);
            if (rb == 32'd0) rb = 32'd1;
            rhi = $urandom % rb;
            rlo = $urandom;
            case ($urandom_range(19))
                0:       do_op({rhi, rlo}, 32'd0);
                1:       do_op({rb + 32'(($urandom % (~rb + 32'd1 == 0 ? 1 : 1))), rlo} | {rb, 32'd0}, rb);
                default: do_op({rhi, rlo}, rb);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "simulation time limit");
    end
endmodule
